// File: rtl/fifo_ctrl_pkg.sv
// Purpose: shared occupancy-state encoding and depth helper for the sync FIFO controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_ctrl_pkg;

    // Occupancy of the FIFO as seen by the controller FSM.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

    // Number of RAM entries addressed by a pointer of the given width.
    function automatic int fifo_depth(input int ptr_width);
        return 1 << ptr_width;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// Purpose: wrapping RAM address counter with increment enable and synchronous clear.
// Latency: the new address appears one i_clk edge after i_inc.
// Backpressure: none; the caller only raises i_inc for accepted operations.
module fifo_ctrl_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int PTR_WIDTH = 10
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [PTR_WIDTH-1:0] o_ptr
);

    localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(fifo_depth(PTR_WIDTH) - 1);

    logic [PTR_WIDTH-1:0] ptr_q;

    // Advance on each accepted operation; wrap explicitly from the last entry back to 0.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            ptr_q <= '0;
        end else if (i_inc) begin
            ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + PTR_WIDTH'(1);
        end
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Purpose: single-clock FIFO controller driving an external RAM (pointers, enables, occupancy flags).
// Latency: RAM enables are combinational from the requests; flags/count/pointers update on the next i_clk edge; o_rd_valid one cycle after a pop.
// Backpressure: pushes are refused while o_full, pops while o_empty; refused requests leave all state untouched.
// Optional sticky overflow/underflow reporting is built only when SYNC_FIFO_CTRL_ERR_EN is defined.
module sync_fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int PTR_WIDTH = 10,
    parameter int AF_THRESH = 1020,
    parameter int AE_THRESH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    output logic                 o_mem_wen,
    output logic [PTR_WIDTH-1:0] o_wptr,
    output logic                 o_mem_ren,
    output logic [PTR_WIDTH-1:0] o_rptr,
    output logic                 o_rd_valid,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almost_full,
    output logic                 o_almost_empty,
`ifdef SYNC_FIFO_CTRL_ERR_EN
    input  logic                 i_err_clr,
    output logic                 o_overflow,
    output logic                 o_underflow,
`endif
    output logic [PTR_WIDTH:0]   o_count
);

    localparam int CNT_W = PTR_WIDTH + 1;
    localparam int DEPTH = fifo_depth(PTR_WIDTH);

    // Count levels cast once so every comparison is width-exact.
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PFULL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL    = CNT_W'(AE_THRESH);

    occ_state_t       state_q;
    occ_state_t       state_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             af_q;
    logic             ae_q;
    logic             rd_valid_q;
    logic             full_q;
    logic             empty_q;
    logic             push_acc;
    logic             pop_acc;

    // Flags are decoded straight from the state register, so they carry no
    // combinational path from the requests.
    assign full_q  = (state_q == FULL);
    assign empty_q = (state_q == EMPTY);

    // Acceptance looks only at registered flags. A reset cycle accepts nothing,
    // which also keeps the RAM enables low while i_rst is high. An empty FIFO
    // never bypasses a same-cycle push to the reader.
    assign push_acc = i_push && !full_q  && !i_rst;
    assign pop_acc  = i_pop  && !empty_q && !i_rst;

    assign o_mem_wen = push_acc;
    assign o_mem_ren = pop_acc;

    // Write and read address counters share one implementation.
    fifo_ctrl_ptr #(
        .PTR_WIDTH (PTR_WIDTH)
    ) u_wptr (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (push_acc),
        .o_ptr (o_wptr)
    );

    fifo_ctrl_ptr #(
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rptr (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (pop_acc),
        .o_ptr (o_rptr)
    );

    // Occupancy moves only when exactly one side is accepted.
    always_comb begin
        count_nxt = count_q;
        unique case ({push_acc, pop_acc})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
        endcase
    end

    // Next occupancy state; transitions into FULL/EMPTY are keyed off the
    // current count so PARTIAL can span a single entry when DEPTH is 2.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            EMPTY: begin
                if (push_acc) begin
                    state_nxt = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push_acc && !pop_acc && (count_q == CNT_PFULL)) begin
                    state_nxt = FULL;
                end else if (pop_acc && !push_acc && (count_q == CNT_ONE)) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop_acc) begin
                    state_nxt = PARTIAL;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Count and threshold flags update together so they never disagree.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_nxt;
            af_q    <= (count_nxt >= AF_LVL);
            ae_q    <= (count_nxt <= AE_LVL);
        end
    end

    // Read data from the RAM is registered, so valid trails the accepted pop by
    // one cycle; reset drops any valid still in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop_acc;
        end
    end

    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = af_q;
    assign o_almost_empty = ae_q;
    assign o_count        = count_q;
    assign o_rd_valid     = rd_valid_q;

`ifdef SYNC_FIFO_CTRL_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky error flags: a fresh violation in the clear cycle keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (i_push && full_q) begin
                ovf_q <= 1'b1;
            end else if (i_err_clr) begin
                ovf_q <= 1'b0;
            end
            if (i_pop && empty_q) begin
                udf_q <= 1'b1;
            end else if (i_err_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Purpose: directed self-checking bench for sync_fifo_ctrl at DEPTH 4 (AF 3, AE 1).
// Latency: inputs are driven 1 ns after each rising edge, outputs sampled 1 ns later.
// Backpressure: exercises full/empty refusal, simultaneous push/pop and mid-stream reset.
module tb_sync_fifo_ctrl;

    localparam int PW = 2;

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    logic          err_clr;
    logic          mem_wen;
    logic          mem_ren;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
    logic [PW:0]   count;
`ifdef SYNC_FIFO_CTRL_ERR_EN
    logic          ovf;
    logic          udf;
`endif

    int checks = 0;
    int errors = 0;

    sync_fifo_ctrl #(
        .PTR_WIDTH (PW),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_push         (push),
        .i_pop          (pop),
        .o_mem_wen      (mem_wen),
        .o_wptr         (wptr),
        .o_mem_ren      (mem_ren),
        .o_rptr         (rptr),
        .o_rd_valid     (rd_valid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (af),
        .o_almost_empty (ae),
`ifdef SYNC_FIFO_CTRL_ERR_EN
        .i_err_clr      (err_clr),
        .o_overflow     (ovf),
        .o_underflow    (udf),
`endif
        .o_count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wptr"},  32'(wptr), 0);
        chk({tag, "_rptr"},  32'(rptr), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_ae"},    32'(ae), 1);
        chk({tag, "_full"},  32'(full), 0);
        chk({tag, "_af"},    32'(af), 0);
        chk({tag, "_rdv"},   32'(rd_valid), 0);
`ifdef SYNC_FIFO_CTRL_ERR_EN
        chk({tag, "_ovf"},   32'(ovf), 0);
        chk({tag, "_udf"},   32'(udf), 0);
`endif
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requests high: enables must stay low.
        rst = 1'b1; push = 1'b1; pop = 1'b1; err_clr = 1'b0;
        #1;
        chk("rst_wen", 32'(mem_wen), 0);
        chk("rst_ren", 32'(mem_ren), 0);
        tick;
        tick;
        chk_reset_state("por");
        rst = 1'b0; push = 1'b0; pop = 1'b0;
        tick;

        // Fill to full: write addresses 0..3, af from count 3, full at 4.
        for (int i = 0; i < 4; i++) begin
            push = 1'b1;
            #1;
            chk("fill_wen",  32'(mem_wen), 1);
            chk("fill_wptr", 32'(wptr), 32'(i));
            tick;
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af",    32'(af), (i + 1 >= 3) ? 1 : 0);
            chk("fill_full",  32'(full), (i == 3) ? 1 : 0);
            chk("fill_rdv",   32'(rd_valid), 0);
        end
        push = 1'b0;
        chk("fill_wrap", 32'(wptr), 0);
        chk("fill_ae",   32'(ae), 0);
        chk("fill_empty", 32'(empty), 0);

        // Push into a full FIFO is refused.
        push = 1'b1;
        #1;
        chk("ovf_wen", 32'(mem_wen), 0);
        tick;
        push = 1'b0;
        chk("ovf_wptr",  32'(wptr), 0);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_full",  32'(full), 1);
`ifdef SYNC_FIFO_CTRL_ERR_EN
        chk("ovf_set", 32'(ovf), 1);
        tick;
        chk("ovf_sticky", 32'(ovf), 1);
        err_clr = 1'b1; push = 1'b1;
        tick;
        chk("ovf_set_wins", 32'(ovf), 1);
        push = 1'b0;
        tick;
        err_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);
`endif

        // Full with push+pop: only the pop goes through.
        push = 1'b1; pop = 1'b1;
        #1;
        chk("fpp_wen",  32'(mem_wen), 0);
        chk("fpp_ren",  32'(mem_ren), 1);
        chk("fpp_rptr", 32'(rptr), 0);
        tick;
        push = 1'b0; pop = 1'b0;
        chk("fpp_count", 32'(count), 3);
        chk("fpp_full",  32'(full), 0);
        chk("fpp_empty", 32'(empty), 0);
        chk("fpp_rdv",   32'(rd_valid), 1);
        chk("fpp_rptr1", 32'(rptr), 1);
        chk("fpp_wptr",  32'(wptr), 0);
        chk("fpp_af",    32'(af), 1);

        // Pop, then reset on the following cycle.
        pop = 1'b1;
        tick;
        chk("mid_count", 32'(count), 2);
        chk("mid_rdv",   32'(rd_valid), 1);
        chk("mid_rptr",  32'(rptr), 2);
        chk("mid_af",    32'(af), 0);
        rst = 1'b1; push = 1'b1; pop = 1'b1;
        #1;
        chk("mid_rst_wen", 32'(mem_wen), 0);
        chk("mid_rst_ren", 32'(mem_ren), 0);
        tick;
        chk_reset_state("mid");
        rst = 1'b0; push = 1'b0; pop = 1'b0;
        tick;

        // Empty with push+pop: push accepted, pop refused, no read valid.
        push = 1'b1; pop = 1'b1;
        #1;
        chk("epp_wen", 32'(mem_wen), 1);
        chk("epp_ren", 32'(mem_ren), 0);
        tick;
        push = 1'b0; pop = 1'b0;
        chk("epp_count", 32'(count), 1);
        chk("epp_rdv",   32'(rd_valid), 0);
        chk("epp_empty", 32'(empty), 0);
        chk("epp_ae",    32'(ae), 1);
        chk("epp_wptr",  32'(wptr), 1);
        chk("epp_rptr",  32'(rptr), 0);
`ifdef SYNC_FIFO_CTRL_ERR_EN
        chk("udf_set", 32'(udf), 1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("udf_clr", 32'(udf), 0);
`endif

        // Bring count to 2, then stream push+pop for 6 cycles.
        push = 1'b1;
        tick;
        chk("pre_count", 32'(count), 2);
        chk("pre_ae",    32'(ae), 0);
        pop = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk("str_wen", 32'(mem_wen), 1);
            chk("str_ren", 32'(mem_ren), 1);
            tick;
            chk("str_count", 32'(count), 2);
            chk("str_rdv",   32'(rd_valid), 1);
            chk("str_wptr",  32'(wptr), 32'((2 + k) % 4));
            chk("str_rptr",  32'(rptr), 32'(k % 4));
        end
        push = 1'b0; pop = 1'b0;
        tick;
        chk("str_end_rdv",   32'(rd_valid), 0);
        chk("str_end_count", 32'(count), 2);

        // Drain to empty, then try popping an empty FIFO.
        pop = 1'b1;
        tick;
        chk("drn_count1", 32'(count), 1);
        chk("drn_ae",     32'(ae), 1);
        chk("drn_empty1", 32'(empty), 0);
        chk("drn_rdv1",   32'(rd_valid), 1);
        tick;
        chk("drn_count0", 32'(count), 0);
        chk("drn_empty0", 32'(empty), 1);
        chk("drn_rdv0",   32'(rd_valid), 1);
        #1;
        chk("drn_ren", 32'(mem_ren), 0);
        tick;
        pop = 1'b0;
        chk("drn_rdv_none", 32'(rd_valid), 0);
        chk("drn_count",    32'(count), 0);
        chk("drn_rptr",     32'(rptr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 Parameter PTR_WIDTH, default 10, SHALL set RAM address width; DEPTH = 2**PTR_WIDTH entries.
REQ-002 Parameter AF_THRESH, default 1020, SHALL set the almost-full level; legal range 1..DEPTH.
REQ-003 Parameter AE_THRESH, default 4, SHALL set the almost-empty level; legal range 0..DEPTH-1.
REQ-004 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_push  in  1  write request; data is presented to the RAM by the requester.
REQ-007 i_pop  in  1  read request.
REQ-008 o_mem_wen  out  1  RAM write enable, one per accepted push.
REQ-009 o_wptr  out  PTR_WIDTH  RAM write address.
REQ-010 o_mem_ren  out  1  RAM read enable, one per accepted pop.
REQ-011 o_rptr  out  PTR_WIDTH  RAM read address.
REQ-012 o_rd_valid  out  1  RAM read data valid.
REQ-013 o_full, o_empty, o_almost_full, o_almost_empty  out  1 each  occupancy flags.
REQ-014 o_count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 i_err_clr in 1; o_overflow, o_underflow out 1 each; present only per REQ-033.

Function
REQ-016 Push acceptance SHALL be i_push && !o_full, and pop acceptance SHALL be i_pop && !o_empty, both evaluated on registered flags.
REQ-017 o_mem_wen SHALL equal push acceptance combinationally, and o_mem_ren SHALL equal pop acceptance combinationally.
REQ-018 o_wptr and o_rptr SHALL be registers, each incrementing by 1 on its accept and wrapping DEPTH-1 -> 0.
REQ-019 o_rd_valid SHALL assert exactly one cycle after each accepted pop, matching the registered RAM output latency of 1.
REQ-020 o_count SHALL change as follows: +1 on push-only accept, -1 on pop-only accept, unchanged on both or neither.
REQ-021 When o_full is set, a push SHALL be rejected even if a pop is accepted in the same cycle; the count then decrements.
REQ-022 When o_empty is set, a pop SHALL be rejected even if a push occurs in the same cycle, with no bypass; the count then increments.
REQ-023 Occupancy FSM states SHALL be EMPTY, PARTIAL and FULL.
REQ-024 FSM transitions SHALL be:
  - EMPTY -> PARTIAL on push accept.
  - PARTIAL -> FULL on push-only accept when count == DEPTH-1.
  - PARTIAL -> EMPTY on pop-only accept when count == 1.
  - FULL -> PARTIAL on pop accept.
  - All other cases hold the current state.
REQ-025 o_empty SHALL be (state == EMPTY) and o_full SHALL be (state == FULL), both registered.
REQ-026 o_almost_full SHALL be (o_count >= AF_THRESH) and o_almost_empty SHALL be (o_count <= AE_THRESH), both registered and updated in the same cycle as o_count.
REQ-027 Rejected requests SHALL have no side effect other than the error flags of REQ-033.
REQ-028 When PTR_WIDTH == 1 (DEPTH 2), the block SHALL operate correctly: the PARTIAL state holds count 1 only.

Reset
REQ-029 While i_rst is high at a clock edge, the following SHALL hold:
  - State = EMPTY; o_wptr = 0; o_rptr = 0; o_count = 0.
  - o_empty = 1; o_almost_empty = 1; o_full = 0; o_almost_full = 0.
  - o_rd_valid = 0; o_overflow = 0; o_underflow = 0.
REQ-030 During a reset cycle, o_mem_wen and o_mem_ren SHALL be forced to 0 regardless of i_push and i_pop.
REQ-031 Reset asserted mid-operation SHALL discard all occupancy, and a pending o_rd_valid SHALL be suppressed in the cycle after reset.
REQ-032 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-033 With macro SYNC_FIFO_CTRL_ERR_EN defined, the error logic SHALL be as follows:
  - o_overflow becomes sticky-set on i_push && o_full.
  - o_underflow becomes sticky-set on i_pop && o_empty.
  - Both clear on i_err_clr; a set in the same cycle as i_err_clr wins.
REQ-034 Without SYNC_FIFO_CTRL_ERR_EN, the ports i_err_clr, o_overflow and o_underflow SHALL be absent and no error logic SHALL be synthesised.

Structure
REQ-035 Shared package fifo_ctrl_pkg SHALL hold:
  - The occupancy state encoding: EMPTY = 2'd0, PARTIAL = 2'd1, FULL = 2'd2.
  - The DEPTH derivation helper.
REQ-036 Both pointers SHALL be built from one sub-module, fifo_ctrl_ptr: a wrapping PTR_WIDTH counter with increment enable and synchronous clear, instantiated twice.

Verification (PTR_WIDTH=2, AF_THRESH=3, AE_THRESH=1 unless stated)
REQ-037 Reset, then 4 pushes -> o_wptr 0,1,2,3 then wraps to 0; o_count 4; o_full = 1; o_almost_full asserted from count 3.
REQ-038 FIFO full, 5th push with err macro defined -> o_mem_wen = 0; o_wptr unchanged; o_overflow = 1 until i_err_clr.
REQ-039 Empty, push+pop in the same cycle -> push accepted, pop rejected; o_count = 1; no o_rd_valid.
REQ-040 Count 2, push+pop for 6 cycles -> o_count stays 2; both pointers wrap; o_rd_valid high in cycles 2..7.
REQ-041 Full, push+pop together -> pop only accepted; o_count = 3; FSM state = PARTIAL.
REQ-042 Count 3, pop then i_rst asserted the next cycle -> all outputs at reset values; o_rd_valid = 0 after the reset edge.
